// File: rtl/readout_rx_pkg.sv
// Shared readout_rx constants: default widths, length reset value and the
// integration FSM state encoding.
package readout_rx_pkg;

    localparam int READOUT_RX_DATA_WIDTH       = 8;
    localparam int READOUT_RX_ACCUM_HEADROOM   = 10;
    localparam int READOUT_RX_LENGTH_WIDTH     = 10;
    localparam int READOUT_RX_LENGTH_RESET_VAL = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } integ_state_t;

endpackage

// File: rtl/readout_rx_accum_lane.sv
// One I or Q lane: sign-extend a sample and add it to the running sum.
// Combinational, zero latency; no flow control (caller decides when to use sum).
// READOUT_RX_ACCUM_SATURATE_EN clamps the add; otherwise it wraps two's-complement.
module readout_rx_accum_lane #(
    parameter int DATA_WIDTH        = 8,
    parameter int ACCUMULATOR_WIDTH = 18
) (
    input  logic signed [ACCUMULATOR_WIDTH-1:0] acc,
    input  logic signed [DATA_WIDTH-1:0]        sample,
    output logic signed [ACCUMULATOR_WIDTH-1:0] sum
);

    // One guard bit so overflow shows up as a mismatch of the top two bits.
    logic [ACCUMULATOR_WIDTH:0] wide;

    assign wide = {acc[ACCUMULATOR_WIDTH-1], acc}
                + {{(ACCUMULATOR_WIDTH + 1 - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};

`ifdef READOUT_RX_ACCUM_SATURATE_EN
    always_comb begin
        sum = wide[ACCUMULATOR_WIDTH-1:0];
        if (wide[ACCUMULATOR_WIDTH] != wide[ACCUMULATOR_WIDTH-1]) begin
            sum = wide[ACCUMULATOR_WIDTH]
                ? {1'b1, {(ACCUMULATOR_WIDTH-1){1'b0}}}
                : {1'b0, {(ACCUMULATOR_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = wide[ACCUMULATOR_WIDTH-1:0];
`endif

endmodule

// File: rtl/readout_rx_iq_accumulator.sv
// Integrates LENGTH demodulated I/Q samples per window into registered sums.
// Sums update on the edge accepting the last sample; finish pulses the next cycle.
// sample_valid low simply stalls the window; READOUT_RX_ACCUM_SATURATE_EN selects clamping.
module readout_rx_iq_accumulator
    import readout_rx_pkg::*;
#(
    parameter int DATA_WIDTH        = READOUT_RX_DATA_WIDTH,
    parameter int ACCUMULATOR_WIDTH = DATA_WIDTH + READOUT_RX_ACCUM_HEADROOM,
    parameter int LENGTH_WIDTH      = READOUT_RX_LENGTH_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                integ_len_wr_en,
    input  logic [LENGTH_WIDTH-1:0]             integ_len_wr_data,
    input  logic                                start,
    input  logic                                sample_valid,
    input  logic signed [DATA_WIDTH-1:0]        i_in,
    input  logic signed [DATA_WIDTH-1:0]        q_in,
    output logic signed [ACCUMULATOR_WIDTH-1:0] i_sum_out,
    output logic signed [ACCUMULATOR_WIDTH-1:0] q_sum_out,
    output logic                                finish_count_out,
    output logic                                busy
);

    integ_state_t                         state, next_state;
    logic [LENGTH_WIDTH-1:0]              len_reg;
    logic [LENGTH_WIDTH-1:0]              count;
    logic signed [ACCUMULATOR_WIDTH-1:0]  i_acc, q_acc;
    logic signed [ACCUMULATOR_WIDTH-1:0]  i_next, q_next;
    logic                                 accept;
    logic                                 last;

    assign accept = (state == ST_ACCUM) && sample_valid;
    assign last   = (count == LENGTH_WIDTH'(1));

    readout_rx_accum_lane #(
        .DATA_WIDTH        (DATA_WIDTH),
        .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH)
    ) u_lane_i (
        .acc    (i_acc),
        .sample (i_in),
        .sum    (i_next)
    );

    readout_rx_accum_lane #(
        .DATA_WIDTH        (DATA_WIDTH),
        .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH)
    ) u_lane_q (
        .acc    (q_acc),
        .sample (q_in),
        .sum    (q_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start wins in every state, so a restart mid-window or in DONE behaves alike.
    always_comb begin
        next_state       = state;
        busy             = 1'b0;
        finish_count_out = 1'b0;
        if (start) begin
            next_state = (len_reg == '0) ? ST_DONE : ST_ACCUM;
        end else begin
            case (state)
                ST_IDLE:  next_state = ST_IDLE;
                ST_ACCUM: if (accept && last) next_state = ST_DONE;
                ST_DONE:  next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
        busy             = (state == ST_ACCUM);
        finish_count_out = (state == ST_DONE);
    end

    // len_reg is sampled by start before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg   <= LENGTH_WIDTH'(READOUT_RX_LENGTH_RESET_VAL);
            count     <= '0;
            i_acc     <= '0;
            q_acc     <= '0;
            i_sum_out <= '0;
            q_sum_out <= '0;
        end else begin
            if (integ_len_wr_en) begin
                len_reg <= integ_len_wr_data;
            end
            if (start) begin
                i_acc <= '0;
                q_acc <= '0;
                count <= len_reg;
                if (len_reg == '0) begin
                    i_sum_out <= '0;
                    q_sum_out <= '0;
                end
            end else if (accept) begin
                i_acc <= i_next;
                q_acc <= q_next;
                count <= count - LENGTH_WIDTH'(1);
                if (last) begin
                    i_sum_out <= i_next;
                    q_sum_out <= q_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_readout_rx_iq_accumulator.sv
// Directed bench for readout_rx_iq_accumulator: a window-level reference model checked
// every cycle on a default-width and a 9-bit-accumulator instance, plus literal checks.
module tb_readout_rx_iq_accumulator;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              integ_len_wr_en = 1'b0;
    logic [9:0]        integ_len_wr_data = '0;
    logic              start = 1'b0;
    logic              sample_valid = 1'b0;
    logic signed [7:0] i_in = '0;
    logic signed [7:0] q_in = '0;

    logic signed [17:0] w_i_sum, w_q_sum;
    logic               w_fin, w_busy;
    logic signed [8:0]  n_i_sum, n_q_sum;
    logic               n_fin, n_busy;

    int checks = 0;
    int passes = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    readout_rx_iq_accumulator dut_w (
        .clk(clk), .rst(rst),
        .integ_len_wr_en(integ_len_wr_en), .integ_len_wr_data(integ_len_wr_data),
        .start(start), .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
        .i_sum_out(w_i_sum), .q_sum_out(w_q_sum),
        .finish_count_out(w_fin), .busy(w_busy)
    );

    readout_rx_iq_accumulator #(.DATA_WIDTH(8), .ACCUMULATOR_WIDTH(9), .LENGTH_WIDTH(10)) dut_n (
        .clk(clk), .rst(rst),
        .integ_len_wr_en(integ_len_wr_en), .integ_len_wr_data(integ_len_wr_data),
        .start(start), .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
        .i_sum_out(n_i_sum), .q_sum_out(n_q_sum),
        .finish_count_out(n_fin), .busy(n_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic on plain integers, reduced to a w-bit signed result.
    function automatic int add_w(input int a, input int b, input int w);
        int s, lo, hi;
        s  = a + b;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
`ifdef READOUT_RX_ACCUM_SATURATE_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = s & ((1 << w) - 1);
        if (s > hi) s = s - (1 << w);
`endif
        return s;
    endfunction

    // Window model: open flag, samples still owed, running sums per width.
    bit m_open;
    int m_rem, m_len;
    int m_wi, m_wq, m_ni, m_nq;
    int e_wi, e_wq, e_ni, e_nq;
    bit e_fin, e_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_open = 0; m_rem = 0; m_len = 1;
            m_wi = 0; m_wq = 0; m_ni = 0; m_nq = 0;
            e_wi = 0; e_wq = 0; e_ni = 0; e_nq = 0;
            e_fin = 0; e_busy = 0;
        end else begin
            e_fin = 0;
            if (start) begin
                m_rem = m_len;
                m_open = (m_len != 0);
                m_wi = 0; m_wq = 0; m_ni = 0; m_nq = 0;
                if (m_len == 0) begin
                    e_wi = 0; e_wq = 0; e_ni = 0; e_nq = 0;
                    e_fin = 1;
                end
            end else if (m_open && sample_valid) begin
                m_wi = add_w(m_wi, int'(i_in), 18);
                m_wq = add_w(m_wq, int'(q_in), 18);
                m_ni = add_w(m_ni, int'(i_in), 9);
                m_nq = add_w(m_nq, int'(q_in), 9);
                m_rem--;
                if (m_rem == 0) begin
                    m_open = 0;
                    e_wi = m_wi; e_wq = m_wq; e_ni = m_ni; e_nq = m_nq;
                    e_fin = 1;
                end
            end
            if (integ_len_wr_en) m_len = int'(integ_len_wr_data);
            e_busy = m_open;
        end
    end

    always @(negedge clk) begin
        check("model_finish", int'(w_fin), int'(e_fin));
        check("model_busy", int'(w_busy), int'(e_busy));
        check("model_i_sum", int'(w_i_sum), e_wi);
        check("model_q_sum", int'(w_q_sum), e_wq);
        check("model_narrow_i_sum", int'(n_i_sum), e_ni);
        check("model_narrow_q_sum", int'(n_q_sum), e_nq);
        if (w_fin) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sv,
                         input logic signed [7:0] iv, input logic signed [7:0] qv);
        start = st; sample_valid = sv; i_in = iv; q_in = qv;
        tick();
        start = 1'b0; sample_valid = 1'b0; i_in = '0; q_in = '0;
    endtask

    task automatic wr_len(input logic [9:0] v);
        integ_len_wr_en = 1'b1; integ_len_wr_data = v;
        tick();
        integ_len_wr_en = 1'b0;
    endtask

    int p0;

    initial begin
        #2;
        check("reset_i_sum", int'(w_i_sum), 0);
        check("reset_finish", int'(w_fin), 0);
        check("reset_busy", int'(w_busy), 0);
        @(posedge clk); #2 rst = 1'b1;
        tick();

        // Length 4, four back-to-back samples.
        wr_len(10'd4);
        drive(1, 0, 0, 0);
        check("t1_busy", int'(w_busy), 1);
        drive(0, 1, 1, -1);
        drive(0, 1, 2, -1);
        drive(0, 1, 3, -1);
        drive(0, 1, 4, -1);
        check("t1_finish", int'(w_fin), 1);
        check("t1_i_sum", int'(w_i_sum), 10);
        check("t1_q_sum", int'(w_q_sum), -4);
        tick();
        check("t1_finish_drop", int'(w_fin), 0);
        check("t1_i_hold", int'(w_i_sum), 10);

        // Length 3 with idle gaps between samples.
        wr_len(10'd3);
        drive(1, 0, 0, 0);
        drive(0, 1, 5, -8);
        drive(0, 0, 99, 99);
        check("t2_busy_gap", int'(w_busy), 1);
        drive(0, 1, -2, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("t2_busy_gap2", int'(w_busy), 1);
        drive(0, 1, 7, 3);
        check("t2_i_sum", int'(w_i_sum), 10);
        check("t2_q_sum", int'(w_q_sum), -5);
        tick();

        // Restart after two of four samples.
        wr_len(10'd4);
        p0 = pulses;
        drive(1, 0, 0, 0);
        drive(0, 1, 9, 9);
        drive(0, 1, 9, 9);
        drive(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 5, 0);
        check("t3_i_sum", int'(w_i_sum), 20);
        tick(); tick();
        check("t3_pulses", pulses - p0, 1);

        // Start with a same-cycle length write uses the old length (4).
        integ_len_wr_en = 1'b1; integ_len_wr_data = 10'd1;
        drive(1, 0, 0, 0);
        integ_len_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) drive(0, 1, 1, 2);
        check("t4_finish", int'(w_fin), 1);
        check("t4_i_sum", int'(w_i_sum), 4);
        tick();

        // Length 0.
        wr_len(10'd0);
        drive(1, 0, 0, 0);
        check("t5_finish", int'(w_fin), 1);
        check("t5_i_sum", int'(w_i_sum), 0);
        check("t5_busy", int'(w_busy), 0);
        tick();

        // Start during DONE, with a length write mid-window.
        wr_len(10'd2);
        drive(1, 0, 0, 0);
        drive(0, 1, 3, 3);
        drive(0, 1, 4, 4);
        check("t6_finish_done", int'(w_fin), 1);
        drive(1, 0, 0, 0);
        check("t6_busy_restart", int'(w_busy), 1);
        wr_len(10'd4);
        drive(0, 1, 6, 1);
        drive(0, 1, 6, 1);
        check("t6_i_sum", int'(w_i_sum), 12);
        tick();

        // Overflow of the 9-bit instance.
        drive(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 127, -128);
        check("t7_wide_i", int'(w_i_sum), 508);
        check("t7_wide_q", int'(w_q_sum), -512);
`ifdef READOUT_RX_ACCUM_SATURATE_EN
        check("t7_narrow_i", int'(n_i_sum), 255);
        check("t7_narrow_q", int'(n_q_sum), -256);
`else
        check("t7_narrow_i", int'(n_i_sum), -4);
        check("t7_narrow_q", int'(n_q_sum), 0);
`endif
        tick();

        // Reset mid-window.
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 1);
        #2 rst = 1'b0;
        #1;
        check("t8_rst_i_sum", int'(w_i_sum), 0);
        check("t8_rst_q_sum", int'(w_q_sum), 0);
        check("t8_rst_busy", int'(w_busy), 0);
        check("t8_rst_narrow_i", int'(n_i_sum), 0);
        tick(); tick();
        #2 rst = 1'b1;
        p0 = pulses;
        for (int k = 0; k < 6; k++) drive(0, 1, 1, 1);
        check("t8_no_pulse", pulses - p0, 0);
        check("t8_idle_busy", int'(w_busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
